// File: rtl/io_timer_bank.sv
// Bank of down-counting interval timers on the J1 IO bus. There is one shared prescaler.
// Each channel has its own reload, one-shot/auto-reload mode, pending flag and irq enable.
module io_timer_bank #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 16,
    parameter logic [15:0] BASE     = 16'd110,
    parameter int          PRE_W    = 16
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic                io_wr,
    input  logic                io_rd,
    input  logic [15:0]         mem_addr,
    input  logic [15:0]         dout,
    output logic [15:0]         io_din,
    output logic                irq,
    output logic [CHANNELS-1:0] pending
);

    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] auto_q, auto_d;
    logic [CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PRE_W-1:0]    pc_q, pc_d;
    logic                irq_q, irq_d;
    logic                tick;
    logic                in_block;
    logic [15:0]         off;
    logic                unused_io_rd;

    // Reads have no side effects, so the read strobe is not needed.
    assign unused_io_rd = io_rd;

    assign off      = mem_addr - BASE;
    assign in_block = (mem_addr >= BASE);
    assign tick     = (pc_q == '0);
    assign irq      = irq_q;
    assign pending  = pend_q;

    always_comb begin
        pre_d    = pre_q;
        pc_d     = tick ? pre_q : pc_q - 1'b1;
        pend_d   = pend_q;
        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        count_d  = count_q;
        reload_d = reload_q;

        if (io_wr && in_block && off == 16'(3 * CHANNELS)) begin
            pre_d = dout[PRE_W-1:0];
            pc_d  = dout[PRE_W-1:0];
        end
        // Clear first so a hardware set in the same cycle overrides it.
        if (io_wr && in_block && off == 16'(3 * CHANNELS + 1))
            pend_d = pend_q & ~dout[CHANNELS-1:0];

        for (int c = 0; c < CHANNELS; c++) begin
            if (tick && en_q[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - 1'b1;
                end else begin
                    pend_d[c] = 1'b1;
                    if (auto_q[c]) count_d[c] = reload_q[c];
                    else           en_d[c]    = 1'b0;
                end
            end
            // CPU writes come last so they beat the hardware update.
            if (io_wr && in_block && off == 16'(3 * c))
                count_d[c] = dout[WIDTH-1:0];
            if (io_wr && in_block && off == 16'(3 * c + 1))
                reload_d[c] = dout[WIDTH-1:0];
            if (io_wr && in_block && off == 16'(3 * c + 2)) begin
                en_d[c]     = dout[0];
                auto_d[c]   = dout[1];
                irq_en_d[c] = dout[2];
            end
        end

        irq_d = |(pend_q & irq_en_q);
    end

    always_comb begin
        io_din = '0;
        if (in_block) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (off == 16'(3 * c))     io_din = 16'(count_q[c]);
                if (off == 16'(3 * c + 1)) io_din = 16'(reload_q[c]);
                if (off == 16'(3 * c + 2))
                    io_din = {12'd0, pend_q[c], irq_en_q[c], auto_q[c], en_q[c]};
            end
            if (off == 16'(3 * CHANNELS))     io_din = 16'(pre_q);
            if (off == 16'(3 * CHANNELS + 1)) io_din = 16'(pend_q);
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
            end
            en_q     <= '0;
            auto_q   <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            pre_q    <= '0;
            pc_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            pre_q    <= pre_d;
            pc_q     <= pc_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_io_timer_bank.sv
// Directed bench for io_timer_bank with default parameters (4 channels, BASE 110).
// It drives inputs on the falling edge and samples outputs on the falling edge.
module tb_io_timer_bank;

    logic        clk = 1'b0;
    logic        resetq;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic        irq;
    logic [3:0]  pending;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] rv;

    io_timer_bank dut (
        .clk      (clk),
        .resetq   (resetq),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din),
        .irq      (irq),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // The caller is at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_wr    = 1'b1;
        mem_addr = a;
        dout     = d;
        @(negedge clk);
        io_wr    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        io_rd    = 1'b1;
        mem_addr = a;
        #1;
        v        = io_din;
        io_rd    = 1'b0;
    endtask

    initial begin
        resetq   = 1'b0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        mem_addr = 16'd0;
        dout     = 16'd0;

        // Reset state and register map
        @(negedge clk);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_pend", {12'd0, pending}, 16'd0);
        resetq = 1'b1;
        for (int a = 109; a <= 124; a++) begin
            @(negedge clk);
            rd(16'(a), rv);
            chk($sformatf("rst_rd_%0d", a), rv, 16'd0);
        end

        // ch0 auto-reload with PRESCALE=0
        @(negedge clk);
        wr(16'd111, 16'd3);
        wr(16'd110, 16'd3);
        wr(16'd112, 16'd7);                    // E0
        repeat (3) @(negedge clk);             // E3
        chk("c0_pend_e3", {12'd0, pending}, 16'd0);
        @(negedge clk);                        // E4
        chk("c0_pend_e4", {12'd0, pending}, 16'd1);
        chk("c0_irq_e4", {15'd0, irq}, 16'd0);
        @(negedge clk);                        // E5
        chk("c0_irq_e5", {15'd0, irq}, 16'd1);
        rd(16'd110, rv);
        chk("c0_cnt_e5", rv, 16'd2);
        wr(16'd123, 16'd1);                    // E6 W1C
        chk("c0_w1c_pend", {12'd0, pending}, 16'd0);
        @(negedge clk);                        // E7
        chk("c0_w1c_irq", {15'd0, irq}, 16'd0);
        @(negedge clk);                        // E8 next expiry
        chk("c0_period", {12'd0, pending}, 16'd1);

        // W1C colliding with the E12 expiry: set wins
        wr(16'd123, 16'd1);                    // E9
        chk("c0_clr_e9", {12'd0, pending}, 16'd0);
        repeat (2) @(negedge clk);             // E11
        wr(16'd123, 16'd1);                    // E12
        chk("w1c_vs_set", {12'd0, pending}, 16'd1);

        // Disable ch0: counter freezes
        wr(16'd112, 16'd4);                    // E13, last decrement 3->2
        rd(16'd110, rv);
        chk("c0_cnt_e13", rv, 16'd2);
        wr(16'd123, 16'd1);                    // E14
        rd(16'd110, rv);
        chk("c0_frozen", rv, 16'd2);
        @(negedge clk);                        // E15
        chk("c0_irq_off", {15'd0, irq}, 16'd0);

        // ch1 one-shot with PRESCALE=9: ticks at W10, W20, W30
        wr(16'd122, 16'd9);                    // W0
        wr(16'd113, 16'd2);                    // W1
        wr(16'd115, 16'd1);                    // W2
        repeat (27) @(negedge clk);            // W29
        chk("c1_pend_w29", {12'd0, pending}, 16'd0);
        rd(16'd113, rv);
        chk("c1_cnt_w29", rv, 16'd0);
        @(negedge clk);                        // W30
        chk("c1_pend_w30", {12'd0, pending}, 16'd2);
        rd(16'd115, rv);
        chk("c1_ctrl", rv, 16'h0008);
        @(negedge clk);                        // W31
        chk("c1_no_irq", {15'd0, irq}, 16'd0);

        // ch0 and ch2 one-shot from zero; clear ch0 only
        wr(16'd122, 16'd0);                    // F0
        wr(16'd110, 16'd0);                    // F1
        wr(16'd116, 16'd0);                    // F2
        wr(16'd118, 16'd1);                    // F3
        wr(16'd112, 16'd5);                    // F4: ch2 expires
        @(negedge clk);                        // F5: ch0 expires
        chk("f5_pend", {12'd0, pending}, 16'h0007);
        rd(16'd112, rv);
        chk("c0_ctrl_oneshot", rv, 16'h000C);
        @(negedge clk);                        // F6
        chk("f6_irq", {15'd0, irq}, 16'd1);
        wr(16'd123, 16'd1);                    // F7
        chk("f7_pend", {12'd0, pending}, 16'h0006);
        @(negedge clk);                        // F8
        chk("f8_irq", {15'd0, irq}, 16'd0);

        // COUNT write colliding with a tick: write wins
        wr(16'd119, 16'd5);                    // G0
        wr(16'd121, 16'd1);                    // G1
        rd(16'd119, rv);
        chk("c3_cnt_g1", rv, 16'd5);
        wr(16'd119, 16'd9);                    // G2
        rd(16'd119, rv);
        chk("c3_wr_vs_tick", rv, 16'd9);
        @(negedge clk);                        // G3
        rd(16'd119, rv);
        chk("c3_cnt_g3", rv, 16'd8);

        // Async reset mid-count with irq high
        wr(16'd121, 16'd0);
        wr(16'd123, 16'h000F);
        wr(16'd111, 16'd2);                    // H0
        wr(16'd110, 16'd2);                    // H1
        wr(16'd112, 16'd7);                    // H2
        repeat (4) @(negedge clk);             // H6
        chk("h6_irq", {15'd0, irq}, 16'd1);
        #1 resetq = 1'b0;
        #1;
        chk("arst_irq", {15'd0, irq}, 16'd0);
        chk("arst_pend", {12'd0, pending}, 16'd0);
        rd(16'd110, rv);
        chk("arst_cnt", rv, 16'd0);
        @(negedge clk);
        resetq = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_irq", {15'd0, irq}, 16'd0);
        chk("post_pend", {12'd0, pending}, 16'd0);
        rd(16'd110, rv);
        chk("post_cnt", rv, 16'd0);
        rd(16'd112, rv);
        chk("post_ctrl", rv, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
